// File: rtl/libstf_compactor_pkg.sv
// Shared sizing helpers for the ndata keep compactor.
// Kept type-agnostic; element types come in as module parameters.
package libstf_compactor_pkg;

  function automatic int count_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  function automatic int pop_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ndata_i.sv
// ndata stream bundle: N elements per beat with per-element keep.
// m drives a stream, s consumes one.
interface ndata_i #(
  parameter type data_t = logic [31:0],
  parameter int NUM_ELEMENTS = 4
);

  data_t                   data [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] keep;
  logic                    last;
  logic                    valid;
  logic                    ready;

  modport m (
    output data, keep, last, valid,
    input  ready
  );

  modport s (
    input  data, keep, last, valid,
    output ready
  );

endinterface

// File: rtl/ndata_keep_compress.sv
// Packs kept elements of one beat towards index 0.
// Purely combinational; also reports how many were kept.
module ndata_keep_compress
  import libstf_compactor_pkg::*;
#(
  parameter type data_t = logic [31:0],
  parameter int NUM_ELEMENTS = 4,
  localparam int PW = pop_width(NUM_ELEMENTS),
  localparam int XW = slot_width(NUM_ELEMENTS)
) (
  input  data_t                   data [NUM_ELEMENTS],
  input  logic [NUM_ELEMENTS-1:0] keep,
  output data_t                   packed_data [NUM_ELEMENTS],
  output logic [PW-1:0]           pop
);

  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      packed_data[i] = '0;
    end
    // acc is the running prefix sum of keep
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (keep[i]) begin
        packed_data[acc[XW-1:0]] = data[i];
        acc = acc + PW'(1);
      end
    end
    pop = acc;
  end

endmodule

// File: rtl/ndata_compactor.sv
// Turns sparse-keep ndata beats into dense, prefix-keep beats.
// Order kept; packets split on last and never merged.
module ndata_compactor
  import libstf_compactor_pkg::*;
#(
  parameter type data_t = logic [31:0],
  parameter int NUM_ELEMENTS = 4
) (
  input logic clk,
  input logic rst_n,
  ndata_i.s   in,
  ndata_i.m   out
);

  localparam int N  = NUM_ELEMENTS;
  localparam int CW = count_width(N);
  localparam int PW = pop_width(N);
  localparam int IW = $clog2(2 * N);

  data_t         elem_q [2*N];
  data_t         elem_d [2*N];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          last_pending_q;
  logic          last_pending_d;

  data_t         comp [N];
  logic [PW-1:0] pop;

  logic [CW-1:0] out_taken;
  logic [CW-1:0] base;
  logic          out_valid;
  logic          out_last;
  logic          out_fire;
  logic          in_ready;
  logic          in_fire;

  ndata_keep_compress #(
    .data_t      (data_t),
    .NUM_ELEMENTS(N)
  ) u_compress (
    .data       (in.data),
    .keep       (in.keep),
    .packed_data(comp),
    .pop        (pop)
  );

  assign out_valid = (count_q >= CW'(N))
                  || last_pending_q;
  assign out_last  = last_pending_q
                  && (count_q <= CW'(N));
  assign out_fire  = out_valid && out.ready;

  always_comb begin
    out_taken = '0;
    if (out_fire) begin
      out_taken = (count_q >= CW'(N))
                ? CW'(N) : count_q;
    end
  end

  assign base = count_q - out_taken;

  // Reset gating keeps ready low while rst_n is held
  assign in_ready = rst_n
                 && !last_pending_q
                 && (base <= CW'(N));
  assign in_fire  = in.valid && in_ready;

  assign in.ready  = in_ready;
  assign out.valid = out_valid;
  assign out.last  = out_last;

  always_comb begin
    out.keep = '0;
    for (int i = 0; i < N; i++) begin
      out.data[i] = elem_q[i];
      out.keep[i] = CW'(i) < count_q;
    end
  end

  // Shift out what leaves, then append the packed input at base
  always_comb begin
    logic [CW:0]   src;
    logic [IW-1:0] dst;
    for (int k = 0; k < 2 * N; k++) begin
      src = (CW+1)'(k) + {1'b0, out_taken};
      if (src < (CW+1)'(2 * N)) begin
        elem_d[k] = elem_q[src[IW-1:0]];
      end else begin
        elem_d[k] = elem_q[k];
      end
    end
    for (int i = 0; i < N; i++) begin
      dst = IW'(base) + IW'(i);
      if (in_fire && (PW'(i) < pop)) begin
        elem_d[dst] = comp[i];
      end
    end
  end

  always_comb begin
    count_d = base;
    if (in_fire) begin
      count_d = base + CW'(pop);
    end
  end

  always_comb begin
    last_pending_d = last_pending_q;
    if (out_fire && out_last) begin
      last_pending_d = 1'b0;
    end
    if (in_fire && in.last) begin
      last_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      last_pending_q <= 1'b0;
      elem_q         <= '{default: '0};
    end else begin
      count_q        <= count_d;
      last_pending_q <= last_pending_d;
      elem_q         <= elem_d;
    end
  end

endmodule

// File: tb/tb_ndata_compactor.sv
// Bench for ndata_compactor: element-level reference model
// checked every cycle, plus directed literal scenarios.
module tb_ndata_compactor;

  localparam int N = 4;
  typedef logic [31:0] word_t;

  typedef struct {
    word_t       d [N];
    logic [N-1:0] keep;
    logic        last;
    int unsigned cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ndata_i #(.data_t(word_t), .NUM_ELEMENTS(N)) in_if ();
  ndata_i #(.data_t(word_t), .NUM_ELEMENTS(N)) out_if ();

  ndata_compactor #(
    .data_t      (word_t),
    .NUM_ELEMENTS(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_if),
    .out  (out_if)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic rnd_rdy = 1'b0;

  beat_t       out_log [$];
  int unsigned in_cyc [$];
  word_t       exp_q [$];
  logic        lp_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Element-level model: buffered = accepted minus emitted
  always @(negedge clk) begin
    int occ;
    int take;
    int shown;
    logic ev, el, er;
    logic [N-1:0] ek;
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      lp_m = 1'b0;
      chk("rst_valid", 32'(out_if.valid), 0);
      chk("rst_ready", 32'(in_if.ready), 0);
      chk("rst_keep", 32'(out_if.keep), 0);
    end else begin
      occ   = exp_q.size();
      shown = (occ < N) ? occ : N;
      ev    = (occ >= N) || lp_m;
      el    = lp_m && (occ <= N);
      take  = (ev && out_if.ready) ? shown : 0;
      er    = !lp_m && ((occ - take) <= N);
      ek    = '0;
      for (int i = 0; i < N; i++) ek[i] = (i < occ);
      chk("valid", 32'(out_if.valid), 32'(ev));
      chk("in_ready", 32'(in_if.ready), 32'(er));
      if (ev) begin
        chk("last", 32'(out_if.last), 32'(el));
        chk("keep", 32'(out_if.keep), 32'(ek));
        for (int i = 0; i < shown; i++)
          chk("data", out_if.data[i], exp_q[i]);
      end
      if (ev && out_if.ready) begin
        for (int i = 0; i < N; i++) b.d[i] = out_if.data[i];
        b.keep = out_if.keep;
        b.last = out_if.last;
        b.cyc  = cyc;
        out_log.push_back(b);
        repeat (take) void'(exp_q.pop_front());
        if (el) lp_m = 1'b0;
      end
      if (in_if.valid && er) begin
        for (int i = 0; i < N; i++)
          if (in_if.keep[i]) exp_q.push_back(in_if.data[i]);
        if (in_if.last) lp_m = 1'b1;
        in_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_if.ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input word_t d [N],
                      input logic [N-1:0] k,
                      input logic l);
    int t;
    logic acc;
    t = 0;
    for (int i = 0; i < N; i++) in_if.data[i] = d[i];
    in_if.keep  = k;
    in_if.last  = l;
    in_if.valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_if.ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 300) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    in_if.valid = 1'b0;
  endtask

  task automatic dense(input int first, input logic l);
    word_t d [N];
    for (int i = 0; i < N; i++) d[i] = word_t'(first + i);
    send(d, '1, l);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || lp_m) && t < 500) begin
      tick(1);
      t++;
    end
    chk("drain", 32'(t < 500), 1);
  endtask

  task automatic clear_logs();
    out_log.delete();
    in_cyc.delete();
  endtask

  initial begin
    word_t d [N];
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
    in_if.keep  = '0;
    for (int i = 0; i < N; i++) in_if.data[i] = '0;
    out_if.ready = 1'b0;

    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_if.ready), 1);
    tick(1);

    // dense passthrough, 1-cycle latency, no bubbles
    clear_logs();
    out_if.ready = 1'b1;
    dense(0, 1'b0);
    dense(4, 1'b0);
    dense(8, 1'b1);
    tick(3);
    chk("t1_beats", out_log.size(), 3);
    for (int b = 0; b < 3; b++) begin
      chk("t1_keep", 32'(out_log[b].keep), 32'hf);
      chk("t1_last", 32'(out_log[b].last), 32'(b == 2));
      for (int i = 0; i < N; i++)
        chk("t1_data", out_log[b].d[i], word_t'(b * 4 + i));
    end
    chk("t1_latency", out_log[0].cyc, in_cyc[0] + 1);
    chk("t1_nobubble", out_log[2].cyc, out_log[0].cyc + 2);

    // sparse keeps compacted across beats
    clear_logs();
    d = '{32'd10, 32'd11, 32'd12, 32'd13};
    send(d, 4'b0101, 1'b0);
    d = '{32'd20, 32'd21, 32'd22, 32'd23};
    send(d, 4'b1010, 1'b0);
    d = '{32'd30, 32'd31, 32'd32, 32'd33};
    send(d, 4'b0111, 1'b1);
    tick(3);
    chk("t2_beats", out_log.size(), 2);
    chk("t2_d0", out_log[0].d[0], 10);
    chk("t2_d1", out_log[0].d[1], 12);
    chk("t2_d2", out_log[0].d[2], 21);
    chk("t2_d3", out_log[0].d[3], 23);
    chk("t2_k0", 32'(out_log[0].keep), 32'hf);
    chk("t2_l0", 32'(out_log[0].last), 0);
    chk("t2_e0", out_log[1].d[0], 30);
    chk("t2_e1", out_log[1].d[1], 31);
    chk("t2_e2", out_log[1].d[2], 32);
    chk("t2_k1", 32'(out_log[1].keep), 32'h7);
    chk("t2_l1", 32'(out_log[1].last), 1);

    // empty last beat
    clear_logs();
    out_if.ready = 1'b0;
    d = '{32'd0, 32'd0, 32'd0, 32'd0};
    send(d, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t3_ready_low", 32'(in_if.ready), 0);
    chk("t3_valid", 32'(out_if.valid), 1);
    chk("t3_last", 32'(out_if.last), 1);
    chk("t3_keep", 32'(out_if.keep), 0);
    tick(1);
    out_if.ready = 1'b1;
    tick(2);
    chk("t3_beats", out_log.size(), 1);
    chk("t3_lkeep", 32'(out_log[0].keep), 0);
    chk("t3_llast", 32'(out_log[0].last), 1);

    // backpressure for 10 cycles
    clear_logs();
    out_if.ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 5; b++) dense(100 + 4 * b, b == 4);
      end
      begin
        tick(10);
        @(negedge clk);
        chk("t4_ready_low", 32'(in_if.ready), 0);
        chk("t4_accepted", in_cyc.size(), 2);
        tick(1);
        out_if.ready = 1'b1;
      end
    join
    drain();
    tick(1);
    chk("t4_beats", out_log.size(), 5);
    chk("t4_tail", out_log[4].d[3], 119);
    chk("t4_tlast", 32'(out_log[4].last), 1);

    // packets never share a beat
    clear_logs();
    dense(200, 1'b0);
    d = '{32'd204, 32'd205, 32'd206, 32'd207};
    send(d, 4'b0011, 1'b1);
    dense(300, 1'b1);
    tick(3);
    chk("t5_beats", out_log.size(), 3);
    chk("t5_l0", 32'(out_log[0].last), 0);
    chk("t5_k1", 32'(out_log[1].keep), 32'h3);
    chk("t5_l1", 32'(out_log[1].last), 1);
    chk("t5_a1", out_log[1].d[1], 205);
    chk("t5_b0", out_log[2].d[0], 300);
    chk("t5_k2", 32'(out_log[2].keep), 32'hf);

    // reset with six elements buffered
    out_if.ready = 1'b0;
    dense(400, 1'b0);
    d = '{32'd404, 32'd405, 32'd406, 32'd407};
    send(d, 4'b0011, 1'b0);
    @(posedge clk);
    #2;
    chk("t6_valid_pre", 32'(out_if.valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_if.valid), 0);
    chk("t6_ready", 32'(in_if.ready), 0);
    chk("t6_keep", 32'(out_if.keep), 0);
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    out_if.ready = 1'b1;
    dense(500, 1'b1);
    tick(3);
    chk("t6_beats", out_log.size(), 1);
    chk("t6_fresh", out_log[0].d[0], 500);
    chk("t6_last", 32'(out_log[0].last), 1);

    // randomized traffic against the model
    rnd_rdy = 1'b1;
    for (int b = 0; b < 150; b++) begin
      for (int i = 0; i < N; i++) d[i] = word_t'($urandom);
      tick($urandom_range(0, 2));
      send(d, N'($urandom), ($urandom_range(0, 4) == 0));
    end
    dense(1000, 1'b1);
    rnd_rdy = 1'b0;
    tick(1);
    out_if.ready = 1'b1;
    drain();
    tick(2);
    chk("final_empty", exp_q.size(), 0);
    chk("final_valid", 32'(out_if.valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
